// File: rtl/baud_rate_generator_pkg.sv
// Shared UART package: default counter width and baud divisor constants.
// Divisors are stored as (divide ratio - 1), which is the form the
// baud_rate_generator expects on its baud_value input.
package baud_rate_generator_pkg;

    // Default width of the divisor input and of the tick counter
    localparam int DEFAULT_WIDTH = 16;

    // Reference system clock that the constant table below is built for
    localparam int unsigned CLK_HZ_50M = 32'd50_000_000;

    // Divisor constants for a 50 MHz system clock
    localparam logic [15:0] BAUD_9600   = 16'd5207;
    localparam logic [15:0] BAUD_38400  = 16'd1301;
    localparam logic [15:0] BAUD_57600  = 16'd867;
    localparam logic [15:0] BAUD_115200 = 16'd433;

    // Divisor for any other clock/baud pair: round(f_clk / baud) - 1.
    // Intended for elaboration-time constants when new clocks are added.
    function automatic int unsigned calc_baud_value(
        input int unsigned clk_hz,
        input int unsigned baud
    );
        int unsigned ratio;
        ratio = (clk_hz + (baud / 32'd2)) / baud;
        if (ratio == 32'd0) begin
            return 32'd0;
        end else begin
            return ratio - 32'd1;
        end
    endfunction

endpackage

// File: rtl/baud_rate_generator.sv
// Programmable baud tick generator. Divides clk by (baud_value + 1) and
// emits a one-cycle strobe on clk_out at every baud bit boundary. The
// divisor is sampled every cycle, so a new value takes effect from the
// current count position; the comparison uses >= so a divisor reduced
// below the running count wraps on the next edge instead of running
// the counter all the way round.
module baud_rate_generator
    import baud_rate_generator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] baud_value,
    output logic             clk_out
);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic             tick_r;
    logic             tick_nxt_s;

    // Next-state: wrap and strobe at the end of the period, else advance
    always_comb begin
        count_nxt_s = count_r;
        tick_nxt_s  = 1'b0;
        if (count_r >= baud_value) begin
            count_nxt_s = {WIDTH{1'b0}};
            tick_nxt_s  = 1'b1;
        end else begin
            count_nxt_s = count_r + {{(WIDTH-1){1'b0}}, 1'b1};
            tick_nxt_s  = 1'b0;
        end
    end

    // Counter and tick registers; reset clears both with no partial tick
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {WIDTH{1'b0}};
            tick_r  <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            tick_r  <= tick_nxt_s;
        end
    end

    assign clk_out = tick_r;

endmodule

// File: tb/tb_baud_rate_generator.sv
// Directed bench for baud_rate_generator. Edge numbering: edge 1 is the
// first rising edge after reset is released. With baud_value = N held,
// clk_out is expected high right after edges that are multiples of N+1.
module tb_baud_rate_generator;
    import baud_rate_generator_pkg::*;

    logic        clk;
    logic        reset;
    logic [15:0] baud_value;
    logic        clk_out;

    int vectors;
    int miscompares;

    baud_rate_generator #(.WIDTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .baud_value (baud_value),
        .clk_out    (clk_out)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Two reset cycles with the given divisor, then release
    task automatic apply_reset(input logic [15:0] bv);
        reset      = 1'b1;
        baud_value = bv;
        step();
        step();
        reset = 1'b0;
    endtask

    // clk_out stays 0 throughout reset, even at divide-by-1
    task automatic test_reset();
        reset      = 1'b1;
        baud_value = 16'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (clk_out !== 1'b0) begin
                $display("FAIL reset_hold cycle %0d: clk_out=%b expected 0", i, clk_out);
                miscompares++;
            end
        end
        baud_value = 16'd867;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (clk_out !== 1'b0) begin
                $display("FAIL reset_hold_867 cycle %0d: clk_out=%b expected 0", i, clk_out);
                miscompares++;
            end
        end
    endtask

    // Constant divisor: tick exactly at edges (N+1)*m, fixed pulse count
    task automatic test_divide(input string name, input logic [15:0] n,
                               input int edges, input int exp_pulses);
        int  pulses;
        int  period;
        logic exp;
        pulses = 0;
        period = int'(n) + 1;
        apply_reset(n);
        for (int j = 1; j <= edges; j++) begin
            step();
            exp = ((j % period) == 0);
            if (clk_out === 1'b1) pulses++;
            vectors++;
            if (clk_out !== exp) begin
                $display("FAIL %s edge %0d: clk_out=%b expected %b", name, j, clk_out, exp);
                miscompares++;
                break;
            end
        end
        vectors++;
        if (pulses != exp_pulses) begin
            $display("FAIL %s pulse_count: got %0d expected %0d", name, pulses, exp_pulses);
            miscompares++;
        end
    endtask

    // Divisor cut from 867 to 100 at count 500: immediate wrap, then 101
    task automatic test_shrink();
        logic exp;
        apply_reset(BAUD_57600);
        for (int j = 1; j <= 500; j++) begin
            step();
            vectors++;
            if (clk_out !== 1'b0) begin
                $display("FAIL shrink_pre edge %0d: clk_out=%b expected 0", j, clk_out);
                miscompares++;
                break;
            end
        end
        baud_value = 16'd100;
        step();
        vectors++;
        if (clk_out !== 1'b1) begin
            $display("FAIL shrink_wrap: clk_out=%b expected 1", clk_out);
            miscompares++;
        end
        for (int j = 1; j <= 303; j++) begin
            step();
            exp = ((j % 101) == 0);
            vectors++;
            if (clk_out !== exp) begin
                $display("FAIL shrink_post edge %0d: clk_out=%b expected %b", j, clk_out, exp);
                miscompares++;
                break;
            end
        end
    endtask

    // Divisor raised 100 -> 200 at count 50: current period stretches to 201
    task automatic test_stretch();
        logic exp;
        apply_reset(16'd100);
        for (int j = 1; j <= 50; j++) step();
        baud_value = 16'd200;
        for (int j = 51; j <= 201 + 402; j++) begin
            step();
            exp = ((j % 201) == 0);
            vectors++;
            if (clk_out !== exp) begin
                $display("FAIL stretch edge %0d: clk_out=%b expected %b", j, clk_out, exp);
                miscompares++;
                break;
            end
        end
    endtask

    // Reset at count 400: clears on that edge, next tick 868 edges later
    task automatic test_reset_mid();
        logic exp;
        apply_reset(BAUD_57600);
        for (int j = 1; j <= 400; j++) step();
        reset = 1'b1;
        step();
        vectors++;
        if (clk_out !== 1'b0) begin
            $display("FAIL reset_mid_edge: clk_out=%b expected 0", clk_out);
            miscompares++;
        end
        reset = 1'b0;
        for (int j = 1; j <= 868; j++) begin
            step();
            exp = (j == 868);
            vectors++;
            if (clk_out !== exp) begin
                $display("FAIL reset_mid_restart edge %0d: clk_out=%b expected %b", j, clk_out, exp);
                miscompares++;
                break;
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        baud_value  = 16'd0;

        test_reset();
        test_divide("div_57600", BAUD_57600, 6400, 7);
        test_divide("div_115200", BAUD_115200, 1302, 3);
        test_divide("div_9600", BAUD_9600, 10416, 2);
        test_divide("div_by_1", 16'd0, 20, 20);
        test_divide("div_by_2", 16'd1, 20, 10);
        test_shrink();
        test_stretch();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
